// File: rtl/cfg_bank_writer.sv
// Serial-to-parallel writer for a configuration memory bank: shifts one row of
// bits in, then drives the bit-lines and strobes that row's word-line.
//
// state | meaning
// IDLE  | waiting for start, bank lines quiet
// SHIFT | accepting serial bits into the shadow row
// SETUP | bit-lines driven, word-line still low
// PULSE | bit-lines driven, word-line of current row high
// HOLD  | bit-lines driven, word-line released
// DONE  | all rows written, waiting for a new start
module cfg_bank_writer #(
  parameter int BL_WIDTH = 80,
  parameter int NUM_WL   = 80,
  parameter int WL_PULSE = 2
) (
  input  logic                        prog_clk,
  input  logic                        prog_reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [0:BL_WIDTH-1]         bl,
  output logic [0:NUM_WL-1]           wl,
  output logic                        busy,
  output logic                        done,
  output logic [0:$clog2(NUM_WL)-1]   row
);

  localparam int BCW = $clog2(BL_WIDTH + 1);
  localparam int RW  = $clog2(NUM_WL);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [0:BL_WIDTH-1] shadow_q, shadow_d;
  logic [BCW-1:0]      bitcnt_q, bitcnt_d;
  logic [RW-1:0]       row_q, row_d;
  logic [3:0]          pcnt_q, pcnt_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic [0:NUM_WL-1]   wl_q, wl_d;
  logic                din_ready_q, din_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = (state_q == S_SHIFT) && din_valid && din_ready_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bitcnt_d = bitcnt_q;
    row_d    = row_q;
    pcnt_d   = pcnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHIFT;
          row_d    = '0;
          bitcnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (accept) begin
          for (int i = 0; i < BL_WIDTH; i++) begin
            if (bitcnt_q == BCW'(i)) shadow_d[i] = din;
          end
          // Counter parks on the last index; it is cleared when the next row starts.
          if (bitcnt_q == BCW'(BL_WIDTH - 1)) state_d = S_SETUP;
          else                                bitcnt_d = bitcnt_q + BCW'(1);
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        pcnt_d  = 4'(WL_PULSE - 1);
      end
      S_PULSE: begin
        if (pcnt_q == 4'd0) state_d = S_HOLD;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      S_HOLD: begin
        if (row_q == RW'(NUM_WL - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_SHIFT;
          row_d    = row_q + RW'(1);
          bitcnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      row_d    = '0;
      bitcnt_d = '0;
      pcnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they land registered on the same edge.
  always_comb begin
    din_ready_d = (state_d == S_SHIFT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    bl_d        = '0;
    wl_d        = '0;
    if (state_d == S_SETUP || state_d == S_PULSE || state_d == S_HOLD) bl_d = shadow_d;
    if (state_d == S_PULSE) begin
      for (int i = 0; i < NUM_WL; i++) begin
        if (row_d == RW'(i)) wl_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bitcnt_q    <= '0;
      row_q       <= '0;
      pcnt_q      <= '0;
      bl_q        <= '0;
      wl_q        <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bitcnt_q    <= bitcnt_d;
      row_q       <= row_d;
      pcnt_q      <= pcnt_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign din_ready = din_ready_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign row       = row_q;

endmodule
